reset_request_filter: RTL and testbench



---
 rtl/reset_request_filter.sv | 205 ++++++++++++++++++++
 tb/tb_reset_request_filter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_request_filter.sv
// reset_request_filter
//   Qualifies the raw board-level controller reset request before it reaches
//   the global reset synchronizer. The request and the PLL lock are
//   resynchronized into clk_24MHz, the request is debounced in both
//   directions, a power-on delay and a minimum hold time are applied, and a
//   clean active-low reset is produced.
//
// Ports
//   clk_24MHz               in   block clock
//   rst_n                   in   asynchronous active-low reset
//   Controller_Reset_Req_n  in   raw reset request, async, active-low
//   pll_locked              in   PLL lock, async, high = locked
//   Controller_FPGA_Reset   out  qualified reset, active-low, registered
//   reset_active            out  high outside IDLE/QUALIFY, registered
//   reset_count             out  saturating count of reset assertions
module reset_request_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 240,
  parameter int HOLD_CYCLES   = 2400,
  parameter int POR_CYCLES    = 24000,
  parameter int CNT_W         = 16
) (
  input  logic       clk_24MHz,
  input  logic       rst_n,
  input  logic       Controller_Reset_Req_n,
  input  logic       pll_locked,
  output logic       Controller_FPGA_Reset,
  output logic       reset_active,
  output logic [7:0] reset_count
);

  // Elaboration-time parameter sanity. The shift form avoids overflowing
  // 2**CNT_W for wide counters.
  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("reset_request_filter: SYNC_STAGES must be >= 2");
    end
    if (CNT_W < 1 || CNT_W > 31) begin : g_bad_cnt_w
      $error("reset_request_filter: CNT_W must be in 1..31");
    end
    if (FILTER_CYCLES < 1 || (FILTER_CYCLES >> CNT_W) != 0) begin : g_bad_filter
      $error("reset_request_filter: FILTER_CYCLES must be in 1..2^CNT_W-1");
    end
    if (HOLD_CYCLES < 0 || (HOLD_CYCLES >> CNT_W) != 0) begin : g_bad_hold
      $error("reset_request_filter: HOLD_CYCLES must be below 2^CNT_W");
    end
    if (POR_CYCLES < 0 || (POR_CYCLES >> CNT_W) != 0) begin : g_bad_por
      $error("reset_request_filter: POR_CYCLES must be below 2^CNT_W");
    end
  endgenerate

  localparam logic [CNT_W-1:0] FILT_C  = CNT_W'(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] FILT_M1 = CNT_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_C  = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] POR_C   = CNT_W'(POR_CYCLES);

  typedef enum logic [2:0] {
    ST_POR     = 3'd0,
    ST_IDLE    = 3'd1,
    ST_QUALIFY = 3'd2,
    ST_ASSERT  = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchronizers: plain shift registers, oldest sample at the MSB.
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] req_pipe;
  logic [SYNC_STAGES-1:0] lock_pipe;
  logic                   req_s;
  logic                   lock_s;

  always_ff @(posedge clk_24MHz or negedge rst_n) begin
    if (!rst_n) begin
      req_pipe  <= '0;
      lock_pipe <= '0;
    end else begin
      req_pipe  <= {req_pipe[SYNC_STAGES-2:0], Controller_Reset_Req_n};
      lock_pipe <= {lock_pipe[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign req_s  = req_pipe[SYNC_STAGES-1];
  assign lock_s = lock_pipe[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Shared timing counter helper: count up, clamp at the phase target.
  // Every target fits in CNT_W bits, so the counter can never wrap.
  // --------------------------------------------------------------------------
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? lim : v + CNT_W'(1);
  endfunction

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             enter_assert;
  logic             out_nx;

  // --------------------------------------------------------------------------
  // Next-state / counter logic.
  // The debounce states leave on the edge whose sample would bring the count
  // to FILTER_CYCLES, i.e. after FILTER_CYCLES consecutive qualifying samples
  // (IDLE contributes the first low sample when it moves to QUALIFY).
  // Lock loss wins over request handling everywhere except POR.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      ST_POR: begin
        if (cnt == POR_C && lock_s && req_s) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = sat_inc(cnt, POR_C);
        end
      end

      ST_IDLE: begin
        if (!lock_s) begin
          state_nx = ST_ASSERT;
          cnt_nx   = '0;
        end else if (!req_s) begin
          state_nx = ST_QUALIFY;
          cnt_nx   = CNT_W'(1);
        end
      end

      ST_QUALIFY: begin
        if (!lock_s) begin
          state_nx = ST_ASSERT;
          cnt_nx   = '0;
        end else if (req_s) begin
          // Glitch shorter than the filter window: drop it.
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else if (cnt >= FILT_M1) begin
          state_nx = ST_ASSERT;
          cnt_nx   = '0;
        end else begin
          cnt_nx = sat_inc(cnt, FILT_C);
        end
      end

      ST_ASSERT: begin
        if (!lock_s) begin
          // Lock dropped again during the hold: restart the hold window.
          cnt_nx = '0;
        end else if (cnt >= HOLD_C && req_s) begin
          state_nx = ST_RELEASE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = sat_inc(cnt, HOLD_C);
        end
      end

      ST_RELEASE: begin
        if (!lock_s) begin
          state_nx = ST_ASSERT;
          cnt_nx   = '0;
        end else if (!req_s) begin
          // Release bounce: require a fresh run of high samples.
          cnt_nx = '0;
        end else if (cnt >= FILT_M1) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = sat_inc(cnt, FILT_C);
        end
      end

      default: begin
        state_nx = ST_POR;
        cnt_nx   = '0;
      end
    endcase
  end

  // Only arrivals from another state count as a new reset assertion.
  assign enter_assert = (state_nx == ST_ASSERT) && (state != ST_ASSERT);
  assign out_nx       = (state_nx == ST_IDLE) || (state_nx == ST_QUALIFY);

  // --------------------------------------------------------------------------
  // State register and registered output decodes of the next state, so the
  // outputs move on the same edge as the transition.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_24MHz or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= ST_POR;
      cnt                   <= '0;
      Controller_FPGA_Reset <= 1'b0;
      reset_active          <= 1'b1;
      reset_count           <= 8'd0;
    end else begin
      state                 <= state_nx;
      cnt                   <= cnt_nx;
      Controller_FPGA_Reset <= out_nx;
      reset_active          <= ~out_nx;
      if (enter_assert && reset_count != 8'hFF)
        reset_count <= reset_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_reset_request_filter.sv
// Bench for reset_request_filter: directed scenarios with timing constants,
// then randomized request / lock / reset activity, all checked every cycle
// against a queue-based behavioural model of the qualification rules.
module tb_reset_request_filter;

  localparam int SYNC = 2;
  localparam int FLT  = 4;
  localparam int HLD  = 10;
  localparam int PORC = 20;

  logic       clk;
  logic       rst_n;
  logic       req;
  logic       lock;
  logic       Controller_FPGA_Reset;
  logic       reset_active;
  logic [7:0] reset_count;

  int vec  = 0;
  int errs = 0;

  reset_request_filter #(
    .SYNC_STAGES  (SYNC),
    .FILTER_CYCLES(FLT),
    .HOLD_CYCLES  (HLD),
    .POR_CYCLES   (PORC),
    .CNT_W        (16)
  ) dut (
    .clk_24MHz             (clk),
    .rst_n                 (rst_n),
    .Controller_Reset_Req_n(req),
    .pll_locked            (lock),
    .Controller_FPGA_Reset (Controller_FPGA_Reset),
    .reset_active          (reset_active),
    .reset_count           (reset_count)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vec++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Synchronizer = a SYNC-deep sample queue; phase held as a name.
  bit    q_req[$];
  bit    q_lock[$];
  string m_mode;
  int    m_t;
  int    m_cnt;

  function automatic void m_reset();
    q_req.delete();
    q_lock.delete();
    for (int i = 0; i < SYNC; i++) begin
      q_req.push_back(1'b0);
      q_lock.push_back(1'b0);
    end
    m_mode = "POR";
    m_t    = 0;
    m_cnt  = 0;
  endfunction

  function automatic void m_go_assert();
    m_mode = "ASSERT";
    m_t    = 0;
    if (m_cnt < 255) m_cnt++;
  endfunction

  function automatic void m_step(input bit r, input bit l);
    bit rq, lk;
    rq = q_req.pop_front();
    lk = q_lock.pop_front();
    q_req.push_back(r);
    q_lock.push_back(l);
    if (m_mode == "POR") begin
      if (m_t == PORC && lk && rq) begin m_mode = "IDLE"; m_t = 0; end
      else if (m_t < PORC) m_t++;
    end else if (m_mode == "IDLE") begin
      if (!lk) m_go_assert();
      else if (!rq) begin m_mode = "QUALIFY"; m_t = 1; end
    end else if (m_mode == "QUALIFY") begin
      if (!lk) m_go_assert();
      else if (rq) begin m_mode = "IDLE"; m_t = 0; end
      else if (m_t + 1 >= FLT) m_go_assert();
      else m_t++;
    end else if (m_mode == "ASSERT") begin
      if (!lk) m_t = 0;
      else if (m_t >= HLD && rq) begin m_mode = "RELEASE"; m_t = 0; end
      else if (m_t < HLD) m_t++;
    end else begin
      if (!lk) m_go_assert();
      else if (!rq) m_t = 0;
      else if (m_t + 1 >= FLT) begin m_mode = "IDLE"; m_t = 0; end
      else m_t++;
    end
  endfunction

  function automatic bit m_out();
    return (m_mode == "IDLE") || (m_mode == "QUALIFY");
  endfunction

  task automatic cmp_model(input string where);
    chk({where, ".fpga_reset"}, 16'(Controller_FPGA_Reset), 16'(m_out()));
    chk({where, ".reset_active"}, 16'(reset_active), 16'(!m_out()));
    chk({where, ".reset_count"}, 16'(reset_count), 16'(m_cnt));
  endtask

  // One clock: drive inputs, take the edge, sample 1 time unit later.
  task automatic step(input logic r, input logic l);
    req  = r;
    lock = l;
    @(posedge clk);
    #1;
    m_step(r, l);
    cmp_model("step");
  endtask

  // Request low for edges 1..low_len of the running count n, high after;
  // stop as soon as the output equals want (bounded).
  task automatic measure(input int low_len, input logic want, inout int n);
    for (int k = 0; k < 300; k++) begin
      n++;
      step((n <= low_len) ? 1'b0 : 1'b1, 1'b1);
      if (Controller_FPGA_Reset === want) return;
    end
  endtask

  task automatic async_reset();
    #5 rst_n = 1'b0;
    #1;
    m_reset();
    chk("async.fpga_reset", 16'(Controller_FPGA_Reset), 16'd0);
    chk("async.reset_active", 16'(reset_active), 16'd1);
    chk("async.reset_count", 16'(reset_count), 16'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    req   = 1'b1;
    lock  = 1'b1;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.fpga_reset", 16'(Controller_FPGA_Reset), 16'd0);
    chk("rst.reset_active", 16'(reset_active), 16'd1);
    chk("rst.reset_count", 16'(reset_count), 16'd0);

    // Power-on delay: output rises on edge POR+1.
    rst_n = 1'b1;
    n = 0;
    measure(0, 1'b1, n);
    chk("por.rise_edge", 16'(n), 16'(PORC + 1));
    chk("por.reset_active", 16'(reset_active), 16'd0);
    chk("por.reset_count", 16'(reset_count), 16'd0);

    // Short glitch is rejected.
    repeat (3) step(1'b0, 1'b1);
    repeat (10) step(1'b1, 1'b1);
    chk("glitch.fpga_reset", 16'(Controller_FPGA_Reset), 16'd1);
    chk("glitch.reset_count", 16'(reset_count), 16'd0);

    // 4-cycle pulse: low after SYNC+FILTER edges, high after hold + release.
    n = 0;
    measure(4, 1'b0, n);
    chk("pulse4.fall_edge", 16'(n), 16'(SYNC + FLT));
    measure(4, 1'b1, n);
    chk("pulse4.rise_edge", 16'(n), 16'd21);
    chk("pulse4.reset_count", 16'(reset_count), 16'd1);

    // Request held for 50 cycles.
    n = 0;
    measure(50, 1'b0, n);
    chk("hold50.fall_edge", 16'(n), 16'(SYNC + FLT));
    measure(50, 1'b1, n);
    chk("hold50.rise_edge", 16'(n), 16'd57);
    chk("hold50.reset_count", 16'(reset_count), 16'd2);

    // Release bounce 1,1,0,1,1,1,1 right after the hold expires.
    n = 0;
    repeat (20) begin n++; step(1'b0, 1'b1); end
    n++; step(1'b1, 1'b1);
    n++; step(1'b1, 1'b1);
    n++; step(1'b0, 1'b1);
    measure(0, 1'b1, n);
    chk("bounce.rise_edge", 16'(n), 16'd29);
    chk("bounce.reset_count", 16'(reset_count), 16'd3);

    // Lock loss in IDLE, then again mid-hold.
    n = 0;
    for (int k = 0; k < 20; k++) begin
      n++;
      step(1'b1, 1'b0);
      if (Controller_FPGA_Reset === 1'b0) break;
    end
    chk("lock.fall_edge", 16'(n), 16'(SYNC + 1));
    chk("lock.reset_count", 16'(reset_count), 16'd4);
    repeat (6) step(1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b0);
    chk("relock.reset_count", 16'(reset_count), 16'd4);
    n = 0;
    measure(0, 1'b1, n);
    chk("relock.rise_edge", 16'(n), 16'd17);

    // Saturation of the assertion counter.
    for (int k = 0; k < 300; k++) begin
      repeat (3) step(1'b1, 1'b0);
      repeat (22) step(1'b1, 1'b1);
    end
    chk("sat.reset_count", 16'(reset_count), 16'd255);

    // Reset mid-ASSERT, then the full POR delay again.
    repeat (8) step(1'b0, 1'b1);
    chk("mid.in_assert", 16'(Controller_FPGA_Reset), 16'd0);
    async_reset();
    n = 0;
    measure(0, 1'b1, n);
    chk("mid.por_rise_edge", 16'(n), 16'(PORC + 1));

    // Randomized request / lock runs with occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic r, l;
      int   len;
      r   = ($urandom_range(0, 3) != 0);
      l   = ($urandom_range(0, 7) != 0);
      len = $urandom_range(1, 14);
      repeat (len) step(r, l);
      if ($urandom_range(0, 59) == 0) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
